mult_share_arbiter: RTL and testbench

Round-robin scheduler that shares one clocked signed multiplier among `N_REQ` requesters. Each requester presents a pair of signed operands with a valid/ready handshake. The arbiter issues at most one operation per cycle to the shared multiplier and tracks in-flight operations with a tag pipeline matched to the multiplier latency. It returns each product with the originating requester's index. It sits between the requester blocks and a `simple_multiplier_final`-style datapath, which stays outside this block.

---
 rtl/mult_share_arbiter_if.sv | 50 +++++
 rtl/mult_share_arbiter.sv | 156 +++++++++++++++
 tb/tb_mult_share_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_share_arbiter_if.sv
// -----------------------------------------------------------------------------
// mult_share_arbiter_if
//
// Bundles every signal between mult_share_arbiter and its environment: the
// requester handshakes, the shared multiplier operand/product bus, and the
// response/status outputs. clk and rst stay plain ports on the modules.
//
//   en         grant enable (low blocks new grants)
//   req_valid  per-requester request valid            [N_REQ]
//   req_a/b    packed signed operands, requester i at [i*DATA_W +: DATA_W]
//   req_ready  one-hot combinational grant            [N_REQ]
//   mul_a/b    registered operands to the multiplier  [DATA_W]
//   mul_p      product from the multiplier            [2*DATA_W]
//   rsp_valid  one-cycle product-available pulse
//   rsp_id     owner of rsp_p                         [$clog2(N_REQ)]
//   rsp_p      signed product                         [2*DATA_W]
//   inflight   accepted operations not yet returned   [4]
//
// slave  : the arbiter's view.
// master : the environment's view (requesters plus the multiplier datapath).
// -----------------------------------------------------------------------------
interface mult_share_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32
);
  localparam int ID_W = $clog2(N_REQ);

  logic                       en;
  logic [N_REQ-1:0]           req_valid;
  logic [N_REQ*DATA_W-1:0]    req_a;
  logic [N_REQ*DATA_W-1:0]    req_b;
  logic [N_REQ-1:0]           req_ready;
  logic [DATA_W-1:0]          mul_a;
  logic [DATA_W-1:0]          mul_b;
  logic [2*DATA_W-1:0]        mul_p;
  logic                       rsp_valid;
  logic [ID_W-1:0]            rsp_id;
  logic [2*DATA_W-1:0]        rsp_p;
  logic [3:0]                 inflight;

  modport slave (
    input  en, req_valid, req_a, req_b, mul_p,
    output req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_p, inflight
  );

  modport master (
    output en, req_valid, req_a, req_b, mul_p,
    input  req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_p, inflight
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// -----------------------------------------------------------------------------
// mult_share_arbiter
//
// Round-robin scheduler sharing one clocked multiplier among N_REQ requesters.
// At most one request is granted per cycle; the winner's operands are
// registered onto mul_a/mul_b and a tag {valid, id} enters a shift register
// of depth MUL_LATENCY+1. When a valid tag reaches the last stage it lines up
// with mul_p, and the product is registered onto rsp_p with rsp_id and a
// one-cycle rsp_valid pulse.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-low reset
//   bus   mult_share_arbiter_if.slave (handshakes, multiplier bus, responses)
// -----------------------------------------------------------------------------
module mult_share_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst,
  mult_share_arbiter_if.slave bus
);
  localparam int ID_W  = $clog2(N_REQ);
  localparam int DEPTH = MUL_LATENCY + 1;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  // Per-requester operand views of the packed buses.
  logic [DATA_W-1:0]   op_a [N_REQ];
  logic [DATA_W-1:0]   op_b [N_REQ];

  logic [ID_W-1:0]     rr_ptr_q,    rr_ptr_d;
  tag_t                tag_q [DEPTH];
  tag_t                tag_d [DEPTH];
  logic [DATA_W-1:0]   mul_a_q,     mul_a_d;
  logic [DATA_W-1:0]   mul_b_q,     mul_b_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]     rsp_id_q,    rsp_id_d;
  logic [2*DATA_W-1:0] rsp_p_q,     rsp_p_d;
  logic [CNT_W-1:0]    inflight_q,  inflight_d;

  logic [N_REQ-1:0]    grant;
  logic [ID_W-1:0]     grant_id;
  logic                accept;
  logic                rsp_fire;
  int                  cand;
  logic [ID_W-1:0]     cand_id;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign op_a[i] = bus.req_a[i*DATA_W +: DATA_W];
    assign op_b[i] = bus.req_b[i*DATA_W +: DATA_W];
  end

  // Search upward from rr_ptr with wrap; the first valid requester wins.
  // Gating with rst keeps req_ready low while reset is asserted.
  always_comb begin : arbitrate
    // NOTE: every signal written here gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    grant    = '0;
    grant_id = '0;
    accept   = 1'b0;
    cand     = 0;
    cand_id  = '0;
    if (rst && bus.en) begin
      for (int k = 0; k < N_REQ; k++) begin
        cand = int'(rr_ptr_q) + k;
        if (cand >= N_REQ) cand = cand - N_REQ;
        cand_id = ID_W'(cand);
        if (!accept && bus.req_valid[cand_id]) begin
          accept          = 1'b1;
          grant_id        = cand_id;
          grant[cand_id]  = 1'b1;
        end
      end
    end
  end

  // The last tag stage is aligned with mul_p for the operands it tracks.
  assign rsp_fire = tag_q[DEPTH-1].valid;

  always_comb begin : next_state
    rr_ptr_d    = rr_ptr_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_p_d     = rsp_p_q;

    tag_d[0].valid = accept;
    tag_d[0].id    = grant_id;
    for (int k = 1; k < DEPTH; k++) begin
      tag_d[k] = tag_q[k-1];
    end

    if (accept) begin
      mul_a_d  = op_a[grant_id];
      mul_b_d  = op_b[grant_id];
      rr_ptr_d = (int'(grant_id) == N_REQ - 1) ? '0 : grant_id + 1'b1;
    end

    if (rsp_fire) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = tag_q[DEPTH-1].id;
      rsp_p_d     = bus.mul_p;
    end

    // Accept and response in the same cycle cancel. The counter peaks at
    // DEPTH, so it cannot wrap.
    inflight_d = inflight_q + CNT_W'(accept) - CNT_W'(rsp_fire);
  end

  always_ff @(posedge clk or negedge rst) begin : regs
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      rr_ptr_q    <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_p_q     <= '0;
      inflight_q  <= '0;
      // NOTE: the tag array is reset entry by entry; in-flight operations must
      // be forgotten, so leaving this storage unreset is not an option here.
      for (int k = 0; k < DEPTH; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_p_q     <= rsp_p_d;
      inflight_q  <= inflight_d;
      for (int k = 0; k < DEPTH; k++) begin
        tag_q[k] <= tag_d[k];
      end
    end
  end

  assign bus.req_ready = grant;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_p     = rsp_p_q;
  assign bus.inflight  = inflight_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mult_share_arbiter
//
// Directed bench for mult_share_arbiter with the default configuration
// (4 requesters, 32-bit operands, multiplier latency 2). A behavioural
// two-stage signed multiplier drives mul_p from mul_a/mul_b.
// -----------------------------------------------------------------------------
module tb_mult_share_arbiter;
  localparam int N_REQ       = 4;
  localparam int DATA_W      = 32;
  localparam int MUL_LATENCY = 2;

  logic clk;
  logic rst;

  int n_cmp = 0;
  int n_err = 0;

  mult_share_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

  mult_share_arbiter #(
    .N_REQ       (N_REQ),
    .DATA_W      (DATA_W),
    .MUL_LATENCY (MUL_LATENCY)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared multiplier: product of the registered operands, MUL_LATENCY edges later.
  logic signed [2*DATA_W-1:0] p_pipe [MUL_LATENCY];
  always @(posedge clk) begin
    p_pipe[0] <= $signed(bus.mul_a) * $signed(bus.mul_b);
    for (int k = 1; k < MUL_LATENCY; k++) p_pipe[k] <= p_pipe[k-1];
  end
  assign bus.mul_p = p_pipe[MUL_LATENCY-1];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    bus.req_a[i*DATA_W +: DATA_W] = a;
    bus.req_b[i*DATA_W +: DATA_W] = b;
  endtask

  logic [31:0] t2_a [4];
  logic [63:0] t2_p [4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    t2_a[0] = -32'sd43;  t2_a[1] = 32'sd23;  t2_a[2] = -32'sd25;  t2_a[3] = 32'sd125;
    t2_p[0] = 64'h0000_0000_0000_0810;
    t2_p[1] = 64'hFFFF_FFFF_FFFF_FEA7;
    t2_p[2] = 64'hFFFF_FFFF_FFFF_FD12;
    t2_p[3] = 64'hFFFF_FFFF_FFFF_F736;

    rst           = 1'b1;
    bus.en        = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;

    // ---------------- Reset values ----------------
    #1 rst = 1'b0;
    #2;
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_id",    64'(bus.rsp_id),    64'd0);
    check("rst_rsp_p",     64'(bus.rsp_p),     64'd0);
    check("rst_mul_a",     64'(bus.mul_a),     64'd0);
    check("rst_mul_b",     64'(bus.mul_b),     64'd0);
    check("rst_inflight",  64'(bus.inflight),  64'd0);

    // All four requesters valid while reset is held: no grant yet.
    bus.en        = 1'b1;
    bus.req_valid = 4'b1111;
    set_op(0, -32'sd43, -32'sd48);
    set_op(1,  32'sd23, -32'sd15);
    set_op(2, -32'sd25,  32'sd30);
    set_op(3, 32'sd125, -32'sd18);
    #1;
    check("rst_ready", 64'(bus.req_ready), 64'd0);

    // ---------------- All four requesters, round robin from 0 ----------------
    @(negedge clk) rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_ready%0d", i), 64'(bus.req_ready), 64'(4'b0001 << i));
      tick();
      bus.req_valid[i] = 1'b0;
      #1;
      check($sformatf("t2_mul_a%0d", i), 64'(bus.mul_a), 64'(t2_a[i]));
    end
    // After the fourth accept edge the first response is already out.
    check("t2_inflight_full", 64'(bus.inflight), 64'd3);
    for (int j = 0; j < 4; j++) begin
      if (j > 0) tick();
      check($sformatf("t2_rsp_valid%0d", j), 64'(bus.rsp_valid), 64'd1);
      check($sformatf("t2_rsp_id%0d", j),    64'(bus.rsp_id),    64'(j));
      check($sformatf("t2_rsp_p%0d", j),     bus.rsp_p,          t2_p[j]);
      check($sformatf("t2_inflight%0d", j),  64'(bus.inflight),  64'(3 - j));
    end
    tick();
    check("t2_rsp_idle", 64'(bus.rsp_valid), 64'd0);

    // ---------------- Requesters 0 and 2 for 10 cycles ----------------
    set_op(0, 32'sd3, 32'sd4);    // 12
    set_op(2, -32'sd5, 32'sd6);   // -30
    bus.req_valid = 4'b0101;
    #1;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t3_ready%0d", i), 64'(bus.req_ready),
            (i % 2 == 0) ? 64'd1 : 64'd4);
      tick();
      check($sformatf("t3_inflight%0d", i), 64'(bus.inflight), (i >= 2) ? 64'd3 : 64'(i + 1));
      if (i >= 3) begin
        check($sformatf("t3_rsp_id%0d", i), 64'(bus.rsp_id),
              ((i - 3) % 2 == 0) ? 64'd0 : 64'd2);
        check($sformatf("t3_rsp_p%0d", i), bus.rsp_p,
              ((i - 3) % 2 == 0) ? 64'd12 : 64'hFFFF_FFFF_FFFF_FFE2);
      end
    end
    bus.req_valid = '0;
    for (int j = 0; j < 3; j++) begin
      tick();
      check($sformatf("t3_drain_valid%0d", j), 64'(bus.rsp_valid), 64'd1);
      check($sformatf("t3_drain_id%0d", j), 64'(bus.rsp_id),
            ((7 + j) % 2 == 0) ? 64'd0 : 64'd2);
      check($sformatf("t3_drain_inflight%0d", j), 64'(bus.inflight), 64'(2 - j));
    end
    tick();
    check("t3_rsp_idle", 64'(bus.rsp_valid), 64'd0);

    // ---------------- Single request, requester 1, 20*75 ----------------
    set_op(1, 32'd20, 32'd75);
    bus.req_valid = 4'b0010;
    #1;
    check("t1_ready", 64'(bus.req_ready), 64'b0010);
    tick();
    bus.req_valid = '0;
    #1;
    check("t1_ready_drop", 64'(bus.req_ready), 64'd0);
    check("t1_mul_a",      64'(bus.mul_a),     64'd20);
    check("t1_mul_b",      64'(bus.mul_b),     64'd75);
    check("t1_inflight1",  64'(bus.inflight),  64'd1);
    tick();
    check("t1_lat1", 64'(bus.rsp_valid), 64'd0);
    tick();
    check("t1_lat2", 64'(bus.rsp_valid), 64'd0);
    tick();
    check("t1_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("t1_rsp_id",    64'(bus.rsp_id),    64'd1);
    check("t1_rsp_p",     bus.rsp_p,          64'd1500);
    check("t1_inflight0", 64'(bus.inflight),  64'd0);
    tick();
    check("t1_pulse",     64'(bus.rsp_valid), 64'd0);
    check("t1_hold_p",    bus.rsp_p,          64'd1500);

    // ---------------- en gating, requester 3 with 10*0 ----------------
    set_op(3, 32'd10, 32'd0);
    bus.req_valid = 4'b1000;
    #1;
    check("t4_ready_en", 64'(bus.req_ready), 64'b1000);
    bus.en = 1'b0;
    #1;
    check("t4_ready_drop", 64'(bus.req_ready), 64'd0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t4_blocked%0d", i), 64'(bus.req_ready), 64'd0);
      tick();
      check($sformatf("t4_hold_a%0d", i), 64'(bus.mul_a), 64'd20);
      check($sformatf("t4_idle%0d", i),   64'(bus.inflight), 64'd0);
    end
    bus.en = 1'b1;
    #1;
    check("t4_ready", 64'(bus.req_ready), 64'b1000);
    tick();
    bus.req_valid = '0;
    check("t4_mul_a", 64'(bus.mul_a), 64'd10);
    check("t4_mul_b", 64'(bus.mul_b), 64'd0);
    tick();
    tick();
    tick();
    check("t4_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("t4_rsp_id",    64'(bus.rsp_id),    64'd3);
    check("t4_rsp_p",     bus.rsp_p,          64'd0);

    // ---------------- Accept coinciding with a response ----------------
    set_op(0, 32'sd7, -32'sd2);   // -14
    bus.req_valid = 4'b0001;
    #1;
    check("t6_ready0", 64'(bus.req_ready), 64'b0001);
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    set_op(2, 32'd10, 32'd1);
    bus.req_valid = 4'b0100;
    #1;
    check("t6_ready2",      64'(bus.req_ready), 64'b0100);
    check("t6_inflight_pre", 64'(bus.inflight), 64'd1);
    tick();
    bus.req_valid = '0;
    check("t6_inflight_same", 64'(bus.inflight), 64'd1);
    check("t6_rsp0_valid",    64'(bus.rsp_valid), 64'd1);
    check("t6_rsp0_id",       64'(bus.rsp_id),    64'd0);
    check("t6_rsp0_p",        bus.rsp_p,          64'hFFFF_FFFF_FFFF_FFF2);
    tick();
    check("t6_gap1", 64'(bus.rsp_valid), 64'd0);
    tick();
    check("t6_gap2", 64'(bus.rsp_valid), 64'd0);
    tick();
    check("t6_rsp2_valid", 64'(bus.rsp_valid), 64'd1);
    check("t6_rsp2_id",    64'(bus.rsp_id),    64'd2);
    check("t6_rsp2_p",     bus.rsp_p,          64'd10);
    check("t6_inflight0",  64'(bus.inflight),  64'd0);

    // ---------------- Reset mid-operation ----------------
    set_op(0, 32'd5, 32'd5);
    set_op(1, 32'd6, 32'd6);
    bus.req_valid = 4'b0011;
    #1;
    check("t5_ready0", 64'(bus.req_ready), 64'b0001);
    tick();
    bus.req_valid = 4'b0010;
    #1;
    check("t5_ready1", 64'(bus.req_ready), 64'b0010);
    tick();
    bus.req_valid = '0;
    check("t5_inflight2", 64'(bus.inflight), 64'd2);
    rst = 1'b0;
    #1;
    check("t5_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("t5_rsp_id",    64'(bus.rsp_id),    64'd0);
    check("t5_rsp_p",     64'(bus.rsp_p),     64'd0);
    check("t5_mul_a",     64'(bus.mul_a),     64'd0);
    check("t5_mul_b",     64'(bus.mul_b),     64'd0);
    check("t5_inflight",  64'(bus.inflight),  64'd0);
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t5_no_rsp%0d", i),   64'(bus.rsp_valid), 64'd0);
      check($sformatf("t5_inflight%0d", i), 64'(bus.inflight),  64'd0);
    end
    // Pointer back at 0: requester 1 wins over 3.
    bus.req_valid = 4'b1010;
    #1;
    check("t5_ptr_reset", 64'(bus.req_ready), 64'b0010);
    bus.req_valid = '0;
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
